// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and the round-robin search helper for the SDRAM read-port arbiter.
package jtframe_sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } arb_state_e;

  localparam int unsigned MaxSlots = 8;

  // First requesting index after ptr, wrapping modulo slots; returns ptr when nobody asks.
  function automatic int unsigned rr_next(input int unsigned slots, input int unsigned ptr,
                                          input logic [MaxSlots-1:0] req_vec);
    int unsigned idx;
    rr_next = ptr;
    // Walk from the farthest candidate inwards so the nearest match wins.
    for (int unsigned k = MaxSlots; k > 0; k--) begin
      if (k <= slots) begin
        idx = ptr + k;
        if (idx >= slots) idx = idx - slots;
        if (req_vec[idx[2:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/jtframe_sdram_arb_rr.sv
// Combinational round-robin picker: first asserted request after ptr, modulo SLOTS.
module jtframe_sdram_arb_rr
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int unsigned SLOTS = 4
) (
  input  logic [SLOTS-1:0]         req,
  input  logic [$clog2(SLOTS)-1:0] ptr,
  output logic [$clog2(SLOTS)-1:0] gnt_idx,
  output logic                     any
);

  localparam int unsigned PW = $clog2(SLOTS);

  logic [MaxSlots-1:0] req_pad;

  always_comb begin
    req_pad            = '0;
    req_pad[SLOTS-1:0] = req;
    gnt_idx            = PW'(rr_next(SLOTS, 32'(ptr), req_pad));
    any                = |req;
  end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port between ROM slots, each with a
// one-word cache; refresh is offered whenever the port has nothing to do.
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 22,
  parameter int unsigned DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en,
  output logic                busy
);

  localparam int unsigned PW = $clog2(SLOTS);

  arb_state_e       state;
  logic [SLOTS-1:0] valid;
  logic [AW-1:0]    cache_addr [SLOTS];
  logic [DW-1:0]    cache_data [SLOTS];
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    pick_idx;
  logic             any_miss;
  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] miss;
  logic [AW-1:0]    pick_addr;

  always_comb begin
    hit       = '0;
    slot_dout = '0;
    for (int i = 0; i < SLOTS; i++) begin
      hit[i]                = valid[i] && (cache_addr[i] == slot_addr[i*AW +: AW]);
      slot_dout[i*DW +: DW] = cache_data[i];
    end
  end

  assign miss       = slot_cs & ~hit;
  // Valid bits clear one cycle after downloading rises, so gate hits right away.
  assign slot_ok    = downloading ? '0 : (slot_cs & hit);
  assign refresh_en = (state == ST_IDLE) && !any_miss && !downloading;
  assign busy       = (state != ST_IDLE);
  assign pick_addr  = slot_addr[32'(pick_idx)*AW +: AW];

  jtframe_sdram_arb_rr #(
    .SLOTS (SLOTS)
  ) u_rr (
    .req     (miss),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (any_miss)
  );

  // sdram_addr doubles as the captured grant address for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      gnt_idx    <= '0;
      rr_ptr     <= '0;
      valid      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        cache_addr[i] <= '0;
        cache_data[i] <= '0;
      end
    end else if (downloading) begin
      state     <= ST_IDLE;
      sdram_req <= 1'b0;
      valid     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_miss) begin
            gnt_idx    <= pick_idx;
            sdram_addr <= pick_addr;
            sdram_req  <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (data_rdy) begin
              cache_data[gnt_idx] <= data_read;
              cache_addr[gnt_idx] <= sdram_addr;
              valid[gnt_idx]      <= 1'b1;
              rr_ptr              <= gnt_idx;
              state               <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (data_rdy) begin
            cache_data[gnt_idx] <= data_read;
            cache_addr[gnt_idx] <= sdram_addr;
            valid[gnt_idx]      <= 1'b1;
            rr_ptr              <= gnt_idx;
            state               <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          sdram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: vector table, directed corner cases, random run.
module tb_jtframe_sdram_arb;

  localparam int SL = 4;
  localparam int AW = 22;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             downloading;
  logic [SL-1:0]    slot_cs;
  logic [SL*AW-1:0] slot_addr;
  logic [SL-1:0]    slot_ok;
  logic [SL*DW-1:0] slot_dout;
  logic             sdram_req;
  logic [AW-1:0]    sdram_addr;
  logic             sdram_ack;
  logic             data_rdy;
  logic [DW-1:0]    data_read;
  logic             refresh_en;
  logic             busy;

  jtframe_sdram_arb #(
    .SLOTS (SL),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  cs;
    logic [21:0] a0;
    logic        ack;
    logic        rdy;
    logic [31:0] dat;
    logic        e_req;
    logic [3:0]  e_ok;
    logic        e_ref;
    logic        e_busy;
    bit          c_addr;
    logic [21:0] e_addr;
    bit          c_dout;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] cs, input logic [21:0] a0, input logic ack,
                              input logic rdy, input logic [31:0] dat, input logic e_req,
                              input logic [3:0] e_ok, input logic e_ref, input logic e_busy,
                              input bit c_addr, input logic [21:0] e_addr, input bit c_dout,
                              input logic [31:0] e_dout);
    vec_t v;
    v.cs = cs; v.a0 = a0; v.ack = ack; v.rdy = rdy; v.dat = dat;
    v.e_req = e_req; v.e_ok = e_ok; v.e_ref = e_ref; v.e_busy = e_busy;
    v.c_addr = c_addr; v.e_addr = e_addr; v.c_dout = c_dout; v.e_dout = e_dout;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1; downloading = 1'b0; slot_cs = '0; slot_addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " req"}, 64'(sdram_req), 64'd1);
  endtask

  // Controller model: ack the cycle after req is seen, data two cycles after the ack.
  task automatic txn(input string nm, input logic [21:0] ea, input logic [31:0] d,
                     input bit chg = 0, input int ci = 0, input logic [21:0] ca = '0);
    wait_req(nm);
    chk({nm, " addr"}, 64'(sdram_addr), 64'(ea));
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    if (chg) slot_addr[ci*AW +: AW] = ca;
    #1;
    chk({nm, " drop"}, 64'(sdram_req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    data_rdy = 1'b1; data_read = d;
    @(negedge clk);
    data_rdy = 1'b0;
    #1;
  endtask

  // Reference model state
  bit          m_valid [SL];
  logic [21:0] m_addr  [SL];
  logic [31:0] m_data  [SL];
  int          m_st;   // 0 idle, 1 request outstanding, 2 waiting for data
  int          m_last;
  int          m_g;
  logic [21:0] m_ga;

  initial begin
    // Single miss, hit, then simultaneous ack + data_rdy
    add(4'h0, 22'h0,     0, 0, 32'h0,        0, 4'h0, 1, 0, 1, 22'h0,   1, 32'h0);
    add(4'h1, 22'h00100, 0, 0, 32'h0,        0, 4'h0, 0, 0, 0, 22'h0,   0, 32'h0);
    add(4'h1, 22'h00100, 0, 0, 32'h0,        1, 4'h0, 0, 1, 1, 22'h100, 0, 32'h0);
    add(4'h1, 22'h00100, 1, 0, 32'h0,        1, 4'h0, 0, 1, 1, 22'h100, 0, 32'h0);
    add(4'h1, 22'h00100, 0, 0, 32'h0,        0, 4'h0, 0, 1, 0, 22'h0,   0, 32'h0);
    add(4'h1, 22'h00100, 0, 0, 32'h0,        0, 4'h0, 0, 1, 0, 22'h0,   0, 32'h0);
    add(4'h1, 22'h00100, 0, 0, 32'h0,        0, 4'h0, 0, 1, 0, 22'h0,   0, 32'h0);
    add(4'h1, 22'h00100, 0, 1, 32'hDEADBEEF, 0, 4'h0, 0, 1, 0, 22'h0,   0, 32'h0);
    add(4'h1, 22'h00100, 0, 0, 32'h0,        0, 4'h1, 1, 0, 0, 22'h0,   1, 32'hDEADBEEF);
    add(4'h0, 22'h00100, 0, 0, 32'h0,        0, 4'h0, 1, 0, 0, 22'h0,   0, 32'h0);
    add(4'h0, 22'h00100, 0, 0, 32'h0,        0, 4'h0, 1, 0, 0, 22'h0,   0, 32'h0);
    add(4'h0, 22'h00100, 0, 0, 32'h0,        0, 4'h0, 1, 0, 0, 22'h0,   0, 32'h0);
    add(4'h1, 22'h00100, 0, 0, 32'h0,        0, 4'h1, 1, 0, 0, 22'h0,   1, 32'hDEADBEEF);
    add(4'h1, 22'h00100, 0, 0, 32'h0,        0, 4'h1, 1, 0, 0, 22'h0,   1, 32'hDEADBEEF);
    add(4'h1, 22'h00104, 0, 0, 32'h0,        0, 4'h0, 0, 0, 0, 22'h0,   0, 32'h0);
    add(4'h1, 22'h00104, 1, 1, 32'h12345678, 1, 4'h0, 0, 1, 1, 22'h104, 0, 32'h0);
    add(4'h1, 22'h00104, 0, 0, 32'h0,        0, 4'h1, 1, 0, 0, 22'h0,   1, 32'h12345678);

    do_reset();
    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      slot_cs = vecs[r].cs; slot_addr[0 +: AW] = vecs[r].a0;
      sdram_ack = vecs[r].ack; data_rdy = vecs[r].rdy; data_read = vecs[r].dat;
      #1;
      chk($sformatf("vec%0d sdram_req", r), 64'(sdram_req), 64'(vecs[r].e_req));
      chk($sformatf("vec%0d slot_ok", r), 64'(slot_ok), 64'(vecs[r].e_ok));
      chk($sformatf("vec%0d refresh_en", r), 64'(refresh_en), 64'(vecs[r].e_ref));
      chk($sformatf("vec%0d busy", r), 64'(busy), 64'(vecs[r].e_busy));
      if (vecs[r].c_addr) chk($sformatf("vec%0d sdram_addr", r), 64'(sdram_addr), 64'(vecs[r].e_addr));
      if (vecs[r].c_dout) chk($sformatf("vec%0d dout0", r), 64'(slot_dout[0 +: DW]), 64'(vecs[r].e_dout));
    end
    @(negedge clk);
    slot_cs = '0; sdram_ack = 1'b0; data_rdy = 1'b0;

    // Round robin: park the pointer on slot 3, then all four slots miss together
    slot_cs = 4'b1000; slot_addr[3*AW +: AW] = 22'h3F0;
    txn("rr park", 22'h3F0, 32'hC0DE0003);
    slot_addr[0*AW +: AW] = 22'h10; slot_addr[1*AW +: AW] = 22'h20;
    slot_addr[2*AW +: AW] = 22'h30; slot_addr[3*AW +: AW] = 22'h40;
    slot_cs = 4'hF;
    txn("rr g0", 22'h10, 32'hA0000010);
    txn("rr g1", 22'h20, 32'hA0000020);
    txn("rr g2", 22'h30, 32'hA0000030);
    txn("rr g3", 22'h40, 32'hA0000040);
    chk("rr all ok", 64'(slot_ok), 64'hF);
    chk("rr dout2", 64'(slot_dout[2*DW +: DW]), 64'hA0000030);

    // Address change after the ack: word stored under the old address
    slot_addr[1*AW +: AW] = 22'h200;
    txn("chg first", 22'h200, 32'hB1000200, 1, 1, 22'h204);
    chk("chg ok1 low", 64'(slot_ok), 64'b1101);
    slot_addr[1*AW +: AW] = 22'h200; #1;
    chk("chg stored addr", 64'(slot_ok), 64'hF);
    chk("chg stored data", 64'(slot_dout[1*DW +: DW]), 64'hB1000200);
    slot_addr[1*AW +: AW] = 22'h204; #1;
    txn("chg second", 22'h204, 32'hB2000204);
    chk("chg ok1 high", 64'(slot_ok), 64'hF);

    // Download flush while a request is outstanding
    @(negedge clk); #1;
    chk("dl pre ok", 64'(slot_ok), 64'hF);
    slot_addr[2*AW +: AW] = 22'h31;
    wait_req("dl");
    downloading = 1'b1; #1;
    chk("dl ok now", 64'(slot_ok), 64'h0);
    chk("dl refresh now", 64'(refresh_en), 64'd0);
    @(negedge clk); #1;
    chk("dl req drop", 64'(sdram_req), 64'd0);
    chk("dl busy", 64'(busy), 64'd0);
    chk("dl refresh", 64'(refresh_en), 64'd0);
    slot_addr[2*AW +: AW] = 22'h30;
    data_rdy = 1'b1; data_read = 32'hBADBAD00;
    @(negedge clk); #1;
    chk("dl ok held", 64'(slot_ok), 64'h0);
    data_rdy = 1'b0; downloading = 1'b0; #1;
    chk("dl after ok", 64'(slot_ok), 64'h0);
    chk("dl after refresh", 64'(refresh_en), 64'd0);
    txn("dl refill", 22'h30, 32'hD0000030);
    chk("dl refill ok", 64'(slot_ok), 64'b0100);
    chk("dl refill data", 64'(slot_dout[2*DW +: DW]), 64'hD0000030);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < SL; i++) begin
      m_valid[i] = 0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_st = 0; m_last = 0; m_g = 0; m_ga = '0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] e_ok;
      logic [3:0] mmiss;
      bit         hit;
      @(negedge clk);
      if (downloading) downloading = ($urandom % 3) != 0;
      else downloading = ($urandom % 60) == 0;
      for (int i = 0; i < SL; i++) begin
        if ($urandom % 8 == 0) slot_cs[i] = 1'($urandom % 2);
        if ($urandom % 10 == 0) slot_addr[i*AW +: AW] = AW'(i * 256 + int'($urandom % 3));
      end
      sdram_ack = 1'b0; data_rdy = 1'b0; data_read = $urandom;
      if (m_st == 1) begin
        sdram_ack = 1'($urandom % 2);
        data_rdy  = sdram_ack && ($urandom % 4 == 0);
      end else if (m_st == 2) begin
        data_rdy = ($urandom % 3) == 0;
      end
      #1;
      e_ok = '0; mmiss = '0;
      for (int i = 0; i < SL; i++) begin
        hit = m_valid[i] && (m_addr[i] == slot_addr[i*AW +: AW]);
        mmiss[i] = slot_cs[i] && !hit;
        e_ok[i]  = slot_cs[i] && hit && !downloading;
      end
      chk("rnd slot_ok", 64'(slot_ok), 64'(e_ok));
      for (int i = 0; i < SL; i++)
        if (e_ok[i]) chk("rnd dout", 64'(slot_dout[i*DW +: DW]), 64'(m_data[i]));
      chk("rnd refresh_en", 64'(refresh_en), 64'(m_st == 0 && mmiss == 0 && !downloading));
      chk("rnd busy", 64'(busy), 64'(m_st != 0));
      chk("rnd sdram_req", 64'(sdram_req), 64'(m_st == 1));
      if (m_st == 1) chk("rnd sdram_addr", 64'(sdram_addr), 64'(m_ga));
      // Advance the model across the coming clock edge
      if (downloading) begin
        for (int i = 0; i < SL; i++) m_valid[i] = 0;
        m_st = 0;
      end else if (m_st == 0) begin
        if (mmiss != 0) begin
          for (int k = SL; k >= 1; k--)
            if (mmiss[(m_last + k) % SL]) m_g = (m_last + k) % SL;
          m_ga = slot_addr[m_g*AW +: AW];
          m_st = 1;
        end
      end else if ((m_st == 1 && sdram_ack) || m_st == 2) begin
        if (data_rdy) begin
          m_valid[m_g] = 1; m_addr[m_g] = m_ga; m_data[m_g] = data_read;
          m_last = m_g; m_st = 0;
        end else begin
          m_st = 2;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
